// File: rtl/rr_mux8_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_mux8_arbiter_if
//
// Purpose:
//   Bundles the request/data inputs and grant/select/mux outputs of the
//   8-source round-robin mux arbiter into one interface.
//
// Signals:
//   req   [7:0]  request per source, bit i = source i
//   din   [7:0]  data bits, din[i] belongs to source i
//   lock         hold the current grant past its tenure limit
//                (only present when RR_MUX8_LOCK_EN is defined)
//   gnt   [7:0]  registered one-hot grant, zero when idle
//   sel   [2:0]  registered binary index of the granted source
//   valid        registered, high while a grant is active
//   z            din[sel] while valid, otherwise 0
//
// Modports:
//   master  requester side: drives req/din(/lock), observes the results
//   slave   arbiter side: consumes req/din(/lock), drives the results
//
// Configuration macro: RR_MUX8_LOCK_EN
// ---------------------------------------------------------------------------
interface rr_mux8_arbiter_if;

    logic [7:0] req;
    logic [7:0] din;
`ifdef RR_MUX8_LOCK_EN
    logic       lock;
`endif
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       z;

`ifdef RR_MUX8_LOCK_EN
    modport master (
        output req,
        output din,
        output lock,
        input  gnt,
        input  sel,
        input  valid,
        input  z
    );

    modport slave (
        input  req,
        input  din,
        input  lock,
        output gnt,
        output sel,
        output valid,
        output z
    );
`else
    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  valid,
        input  z
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output valid,
        output z
    );
`endif

endinterface

// File: rtl/rr_mux8_arbiter.sv
// ---------------------------------------------------------------------------
// rr_mux8_arbiter
//
// Purpose:
//   Round-robin arbiter sharing an 8:1 one-bit mux among 8 requesters.
//   The winner's one-hot grant and binary select are registered, and the
//   selected data bit is driven out on z. A hold counter limits each
//   requester's tenure to MAX_HOLD consecutive cycles so that a source
//   that keeps requesting cannot starve the others.
//
// Parameters:
//   MAX_HOLD  maximum consecutive cycles one source keeps the grant (1..256)
//   HCW       hold counter width, derived from MAX_HOLD; leave at default
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous reset, active-high
//   bus   rr_mux8_arbiter_if.slave: req, din, (lock), gnt, sel, valid, z
//
// Configuration macro:
//   RR_MUX8_LOCK_EN  when defined, adds bus.lock; while a grant is active
//                    and lock is high, the tenure limit is not enforced
//                    (the hold counter saturates), but dropping the
//                    request still releases the grant.
// ---------------------------------------------------------------------------
module rr_mux8_arbiter #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HCW      = $clog2(MAX_HOLD) + 1
) (
    input  logic              clk,
    input  logic              rst,
    rr_mux8_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_ONE = HCW'(1);

    // Registered state
    state_t           state_q;
    logic [7:0]       gnt_q;
    logic [2:0]       sel_q;
    logic             valid_q;
    logic [2:0]       rr_ptr_q;
    logic [HCW-1:0]   hold_cnt_q;

    // Next-state values
    state_t           state_d;
    logic [7:0]       gnt_d;
    logic [2:0]       sel_d;
    logic             valid_d;
    logic [2:0]       rr_ptr_d;
    logic [HCW-1:0]   hold_cnt_d;

    // Arbitration results
    logic [2:0]       scan_start;
    logic [2:0]       cand;
    logic             pick_found;
    logic [2:0]       pick_idx;

    // Tenure decision for the current holder
    logic             hold_ok;
    logic             keep;

    // Round-robin scan. While idle the scan starts at the saved pointer;
    // while a grant is active it starts just past the current holder, so
    // a release or an expiry hands the grant on in the same edge and the
    // holder itself is only reached again after every other source has
    // been considered. The 3-bit index wraps 7->0 on its own.
    always_comb begin
        scan_start = (state_q == GRANT) ? (sel_q + 3'd1) : rr_ptr_q;
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        cand       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = scan_start + 3'(i);
            if (!pick_found && bus.req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // The holder may keep the grant while it still requests and has
    // tenure left. With the lock option a held lock overrides the tenure
    // limit; the lock is only looked at while a grant is active because
    // the decision is only used in GRANT.
    always_comb begin
        hold_ok = (hold_cnt_q < HOLD_MAX);
`ifdef RR_MUX8_LOCK_EN
        hold_ok = hold_ok | bus.lock;
`endif
        keep = bus.req[sel_q] & hold_ok;
    end

    // Next-state and register-update logic. Everything holds by default;
    // a new grant always records the winner, points the round-robin
    // pointer just past it and restarts the tenure count at 1. When the
    // holder releases and nobody else asks, the arbiter drops to IDLE but
    // leaves sel on the last winner so an external mux stays steered.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    gnt_d      = 8'd1 << pick_idx;
                    sel_d      = pick_idx;
                    valid_d    = 1'b1;
                    rr_ptr_d   = pick_idx + 3'd1;
                    hold_cnt_d = HOLD_ONE;
                end
            end

            GRANT: begin
                if (keep) begin
                    // Saturate so a locked holder never wraps the count
                    if (hold_cnt_q < HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + HOLD_ONE;
                    end
                end else if (pick_found) begin
                    // Release with another requester, or expiry (the
                    // holder is still requesting, so a winner always
                    // exists and may be the holder itself)
                    gnt_d      = 8'd1 << pick_idx;
                    sel_d      = pick_idx;
                    valid_d    = 1'b1;
                    rr_ptr_d   = pick_idx + 3'd1;
                    hold_cnt_d = HOLD_ONE;
                end else begin
                    state_d    = IDLE;
                    gnt_d      = 8'd0;
                    valid_d    = 1'b0;
                    rr_ptr_d   = sel_q + 3'd1;
                    hold_cnt_d = '0;
                end
            end

            default: begin
                state_d    = IDLE;
                gnt_d      = 8'd0;
                sel_d      = 3'd0;
                valid_d    = 1'b0;
                rr_ptr_d   = 3'd0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State register. Reset clears the grant immediately and restarts
    // arbitration from source 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 8'd0;
            sel_q      <= 3'd0;
            valid_q    <= 1'b0;
            rr_ptr_q   <= 3'd0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Outputs. The mux bit is gated by valid so an idle arbiter drives 0
    // even though sel still points at the last winner.
    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
    assign bus.z     = valid_q ? bus.din[sel_q] : 1'b0;

endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_mux8_arbiter
//
// Purpose:
//   Directed, self-checking bench for rr_mux8_arbiter with MAX_HOLD=4.
//   Inputs change just after each falling edge and outputs are sampled on
//   the following falling edge, so every sample reflects exactly one
//   rising edge of arbitration.
// ---------------------------------------------------------------------------
module tb_rr_mux8_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    rr_mux8_arbiter_if bus ();

    rr_mux8_arbiter #(
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case the directed sequence ever stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    // Drive requests and data; called right after a falling edge
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] d);
        bus.req = r;
        bus.din = d;
    endtask

    // Compare all four outputs against hand-computed values
    task automatic checkOutput(input string tag, input logic [7:0] eg,
                               input logic [2:0] es, input logic ev,
                               input logic ez);
        checks++;
        assert (bus.gnt === eg) else begin
            errors++;
            $error("[TB] FAIL %s gnt got %h expected %h", tag, bus.gnt, eg);
        end
        checks++;
        assert (bus.sel === es) else begin
            errors++;
            $error("[TB] FAIL %s sel got %0d expected %0d", tag, bus.sel, es);
        end
        checks++;
        assert (bus.valid === ev) else begin
            errors++;
            $error("[TB] FAIL %s valid got %b expected %b", tag, bus.valid, ev);
        end
        checks++;
        assert (bus.z === ez) else begin
            errors++;
            $error("[TB] FAIL %s z got %b expected %b", tag, bus.z, ez);
        end
    endtask

    // Advance to the next falling edge (one rising edge in between)
    task automatic nextCycle();
        @(negedge clk);
    endtask

    // Pulse reset across one rising edge, releasing after a falling edge
    task automatic pulseReset();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_sel;
        logic [7:0] rr_din;

        checks = 0;
        errors = 0;
        rst    = 1'b0;
        applyStimulus(8'h00, 8'h00);
`ifdef RR_MUX8_LOCK_EN
        bus.lock = 1'b0;
`endif

        // Reset and idle
        #1 rst = 1'b1;
        #1 checkOutput("rst_assert", 8'h00, 3'd0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            nextCycle();
            checkOutput($sformatf("idle%0d", k), 8'h00, 3'd0, 1'b0, 1'b0);
        end

        // Single requester: granted for 4 cycles, then re-granted to itself
        applyStimulus(8'h08, 8'h08);
        for (int k = 0; k < 5; k++) begin
            nextCycle();
            checkOutput($sformatf("single%0d", k), 8'h08, 3'd3, 1'b1, 1'b1);
        end
        // Source 5 joins right after the re-grant; source 3 still has three
        // cycles of its reloaded tenure before the grant moves on
        applyStimulus(8'h28, 8'h08);
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            checkOutput($sformatf("reload%0d", k), 8'h08, 3'd3, 1'b1, 1'b1);
        end
        nextCycle();
        checkOutput("expire_to5", 8'h20, 3'd5, 1'b1, 1'b0);
        applyStimulus(8'h00, 8'h08);
        nextCycle();
        checkOutput("release_idle", 8'h00, 3'd5, 1'b0, 1'b0);

        // Round-robin fairness from a fresh reset, all sources requesting
        pulseReset();
        checkOutput("rst2", 8'h00, 3'd0, 1'b0, 1'b0);
        rr_din = 8'hAA;
        applyStimulus(8'hFF, rr_din);
        for (int k = 0; k < 33; k++) begin
            nextCycle();
            exp_sel = 3'((k / 4) % 8);
            checkOutput($sformatf("rr%0d", k), 8'd1 << exp_sel, exp_sel,
                        1'b1, rr_din[exp_sel]);
        end
        applyStimulus(8'h00, rr_din);
        nextCycle();
        checkOutput("rr_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // Release without bubble
        pulseReset();
        applyStimulus(8'h21, 8'h20);
        nextCycle();
        checkOutput("nb_src0", 8'h01, 3'd0, 1'b1, 1'b0);
        applyStimulus(8'h20, 8'h20);
        nextCycle();
        checkOutput("nb_src5", 8'h20, 3'd5, 1'b1, 1'b1);

        // Release to idle leaves pointer at 6; a lone request on 0 wraps
        applyStimulus(8'h00, 8'h01);
        nextCycle();
        checkOutput("idle_ptr6", 8'h00, 3'd5, 1'b0, 1'b0);
        applyStimulus(8'h01, 8'h01);
        nextCycle();
        checkOutput("wrap_ptr6", 8'h01, 3'd0, 1'b1, 1'b1);
        applyStimulus(8'h40, 8'h01);
        nextCycle();
        checkOutput("grant6", 8'h40, 3'd6, 1'b1, 1'b0);
        applyStimulus(8'h01, 8'h01);
        nextCycle();
        checkOutput("wrap_from6", 8'h01, 3'd0, 1'b1, 1'b1);
        applyStimulus(8'h00, 8'h01);
        nextCycle();
        checkOutput("idle_sel0", 8'h00, 3'd0, 1'b0, 1'b0);

        // Async reset mid-grant
        applyStimulus(8'h10, 8'h10);
        nextCycle();
        checkOutput("grant4", 8'h10, 3'd4, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1 checkOutput("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(8'hFF, 8'h01);
        nextCycle();
        checkOutput("post_rst", 8'h01, 3'd0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux8_arbiter.md
Name: rr_mux8_arbiter

Overview:
- Round-robin arbiter that shares an 8:1 one-bit mux among 8 requesters.
- Registers a one-hot grant and the matching 3-bit select, and drives the muxed bit out.
- Bounds each requester's tenure to MAX_HOLD cycles so no requester can starve the others.
- Sits in front of the 8:1 mux datapath; the select is also exported so an external mux instance can be steered.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one requester keeps the grant. Legal range 1..256.
- HCW, $clog2(MAX_HOLD)+1, hold-counter width. Derived; do not override.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous reset, active-high
- req  input  8  request per source; bit i = source i
- din  input  8  data bits; din[i] belongs to source i
- gnt  output 8  registered one-hot grant, all-zero when idle
- sel  output 3  registered mux select, binary index of the granted source
- valid  output 1  registered; high when gnt is non-zero
- z  output 1  din[sel] when valid, else 0 (combinational from din, sel and valid)

Behaviour:
- Reset values (async assert, sync release): gnt=0, sel=0, valid=0, z=0, state=IDLE, rr_ptr=0, hold_cnt=0.
- State IDLE:
  - Any req bit high at edge N moves to GRANT. gnt, sel and valid are updated at edge N, so they are visible in cycle N+1.
  - The winner is the first set bit scanning rr_ptr, rr_ptr+1, ..., wrapping 7->0.
  - hold_cnt loads 1.
- State GRANT, granted index g, evaluated at every edge:
  - Keep: req[g]=1 and hold_cnt<MAX_HOLD. Grant is unchanged; hold_cnt increments.
  - Release: req[g]=0. Re-arbitrate in the same edge from g+1, with no bubble cycle. If no bit is set, go to IDLE: gnt=0, valid=0, sel holds its last value, rr_ptr=g+1 mod 8.
  - Expiry: req[g]=1 and hold_cnt==MAX_HOLD. Re-arbitrate from g+1. If g is the only requester, g is re-granted and hold_cnt reloads 1.
  - Every new grant sets rr_ptr=winner+1 mod 8 and hold_cnt=1.
- Scan wrap: ptr=6 with req=8'b0000_0001 gives winner 0.
- Simultaneous release and new request on the same edge: the new request is eligible in that edge.
- MAX_HOLD=1: the grant rotates every cycle whenever more than one source requests.
- Reset mid-grant: outputs drop to zero immediately (async). After reset, arbitration restarts from index 0.
- Exactly one gnt bit is set whenever valid=1, and gnt[sel]==1.

Optional Feature:
- Macro: RR_MUX8_LOCK_EN
- Defined:
  - Adds input port lock (1 bit), placed after din.
  - While valid=1 and lock=1, the expiry rule is suppressed: the current grant is held as long as req[g]=1 and hold_cnt saturates at MAX_HOLD.
  - Release on req[g]=0 still applies.
  - lock is ignored in IDLE.
- Not defined: no lock port; expiry always applies.

Test Plan:
- Reset/idle: rst=1 then 0, req=0 for 5 cycles -> gnt=0, sel=0, valid=0, z=0 throughout.
- Single requester: req=8'h08, din=8'h08 -> one cycle later gnt=8'h08, sel=3, valid=1, z=1. Held; at cycle 4 (MAX_HOLD=4) source 3 is re-granted with hold_cnt reload and no gap in valid.
- Round-robin fairness: req=8'hFF held for 32 cycles, MAX_HOLD=4 -> sel sequence 0,1,2,...,7, each held 4 cycles, wrapping 7->0.
- Release without bubble: req=8'h21, source 0 granted; drop req[0] -> next edge gnt=8'h20, sel=5, valid stays 1.
- Wrap and idle pointer: grant source 6, then req=8'h01 after 6 releases -> gnt=8'h01, sel=0. Release all -> valid=0, sel stays 0, z=0.
- Async reset mid-grant: while gnt=8'h10, assert rst between edges -> outputs zero before the next edge. After release with req=8'hFF -> first grant is source 0.
